// File: rtl/div_sign_unit.sv
// Signed/unsigned RV32M divide front-end: resolves corner cases locally and
// wraps the multi-cycle unsigned divider with magnitude conversion and sign fix-up.
module div_sign_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  input  logic        div_done_i
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] stage_reg;      // result awaiting its done pulse
  logic [31:0] result_reg;     // last result actually delivered
  logic        rem_sel_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic [31:0] dividend_reg;
  logic [31:0] divisor_reg;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        fast_hit;
  logic [31:0] fast_q;
  logic [31:0] fast_r;
  logic [31:0] fast_res;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] slow_res;

  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & rs1_i[31];
  assign b_neg     = is_signed & rs2_i[31];
  assign a_mag     = a_neg ? (~rs1_i + 32'd1) : rs1_i;
  assign b_mag     = b_neg ? (~rs2_i + 32'd1) : rs2_i;

  // Every case the divider cannot or need not handle (divisor magnitude >= 2^31 included).
  always_comb begin
    fast_hit = 1'b0;
    fast_q   = 32'd0;
    fast_r   = 32'd0;
    if (rs2_i == 32'd0) begin
      fast_hit = 1'b1;
      fast_q   = 32'hFFFF_FFFF;
      fast_r   = rs1_i;
    end else if (is_signed && rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF) begin
      fast_hit = 1'b1;
      fast_q   = 32'h8000_0000;
      fast_r   = 32'd0;
    end else if (!is_signed && rs2_i[31]) begin
      fast_hit = 1'b1;
      fast_q   = {31'd0, (rs1_i >= rs2_i)};
      fast_r   = (rs1_i >= rs2_i) ? (rs1_i - rs2_i) : rs1_i;
    end else if (is_signed && rs2_i == 32'h8000_0000) begin
      fast_hit = 1'b1;
      if (rs1_i == 32'h8000_0000) begin
        fast_q = 32'd1;
        fast_r = 32'd0;
      end else begin
        fast_q = 32'd0;
        fast_r = rs1_i;
      end
    end
  end

  assign fast_res = op_i[1] ? fast_r : fast_q;
  assign q_fix    = q_neg_reg ? (~div_quotient_i + 32'd1) : div_quotient_i;
  assign r_fix    = r_neg_reg ? (~div_remainder_i + 32'd1) : div_remainder_i;
  assign slow_res = rem_sel_reg ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      stage_reg    <= 32'd0;
      result_reg   <= 32'd0;
      rem_sel_reg  <= 1'b0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      dividend_reg <= 32'd0;
      divisor_reg  <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_i && !flush_i) begin
            rem_sel_reg  <= op_i[1];
            q_neg_reg    <= a_neg ^ b_neg;
            r_neg_reg    <= a_neg;
            dividend_reg <= a_mag;
            divisor_reg  <= b_mag;
            if (fast_hit) begin
              stage_reg <= fast_res;
              state_reg <= RESP;
            end else begin
              state_reg <= LAUNCH;
            end
          end
        end
        LAUNCH: state_reg <= flush_i ? DRAIN : WAIT;
        WAIT: begin
          if (div_done_i) begin
            if (!flush_i) stage_reg <= slow_res;
            state_reg <= flush_i ? IDLE : RESP;
          end else if (flush_i) begin
            state_reg <= DRAIN;
          end
        end
        RESP: begin
          if (!flush_i) result_reg <= stage_reg;
          state_reg <= IDLE;
        end
        DRAIN: if (div_done_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A flushed response never becomes visible on result_o.
  assign done_o         = (state_reg == RESP) && !flush_i;
  assign result_o       = done_o ? stage_reg : result_reg;
  assign busy_o         = (state_reg != IDLE);
  assign div_start_o    = (state_reg == LAUNCH);
  assign div_dividend_o = dividend_reg;
  assign div_divisor_o  = divisor_reg;

endmodule

// File: tb/tb_div_sign_unit.sv
// Directed bench for div_sign_unit with a behavioural 36-cycle unsigned divider.
module tb_div_sign_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        busy_o;
  logic        div_start_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [31:0] div_quotient_i;
  logic [31:0] div_remainder_i;
  logic        div_done_i;

  div_sign_unit dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .flush_i(flush_i), .result_o(result_o), .done_o(done_o), .busy_o(busy_o),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i), .div_done_i(div_done_i)
  );

  always #5 clk = ~clk;

  // Divider model: start sampled in cycle 1, done asserted in cycle 36.
  logic [5:0]  dcnt;
  logic [31:0] da, db;
  always @(posedge clk) begin
    if (rst) dcnt <= 6'd0;
    else if (div_start_o) begin
      dcnt <= 6'd35;
      da   <= div_dividend_o;
      db   <= div_divisor_o;
    end else if (dcnt != 6'd0) dcnt <= dcnt - 6'd1;
  end
  assign div_done_i      = (dcnt == 6'd1);
  assign div_quotient_i  = (db != 32'd0) ? da / db : 32'hFFFF_FFFF;
  assign div_remainder_i = (db != 32'd0) ? da % db : da;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the unit idle; that cycle is cycle 0.
  task automatic apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int done_cyc, output int start_cnt,
                       output int start_cyc, output int busy_cnt);
    req_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    res = 32'hDEAD_BEEF; done_cyc = -1; start_cnt = 0; start_cyc = -1; busy_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (div_start_o) begin start_cnt++; start_cyc = n; end
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cyc = n; res = result_o; end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    req_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t vecs[19];

  logic [31:0] res;
  int done_cyc, start_cnt, start_cyc, busy_cnt;
  logic seen_done, busy_gap;

  initial begin
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[6]  = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    vecs[7]  = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0};
    vecs[8]  = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};
    vecs[9]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[10] = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1};
    vecs[11] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[12] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[13] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          1'b1};
    vecs[14] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  1'b1};
    vecs[15] = '{2'b00, 32'h8000_0000,  32'h8000_0000,  32'd1,          1'b1};
    vecs[16] = '{2'b10, 32'd12345,      32'h8000_0000,  32'd12345,      1'b1};
    vecs[17] = '{2'b01, 32'd5,          32'h9000_0000,  32'd0,          1'b1};
    vecs[18] = '{2'b11, 32'd5,          32'h9000_0000,  32'd5,          1'b1};

    rst = 1'b1; req_i = 1'b0; op_i = 2'b00; rs1_i = 32'd0; rs2_i = 32'd0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", result_o, 32'd0);
    check("reset_flags", {29'd0, done_o, busy_o, div_start_o}, 32'd0);
    check("reset_dividend", div_dividend_o, 32'd0);
    check("reset_divisor", div_divisor_o, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, res, done_cyc, start_cnt, start_cyc, busy_cnt);
      $display("vec %0d op=%0d a=%h b=%h -> %h at cycle %0d", i, vecs[i].op, vecs[i].a, vecs[i].b, res, done_cyc);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].fast ? 32'd1 : 32'd37);
      check($sformatf("v%0d_start_count", i), start_cnt, vecs[i].fast ? 32'd0 : 32'd1);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].fast ? 32'd1 : 32'd37);
      if (!vecs[i].fast) check($sformatf("v%0d_start_cycle", i), start_cyc, 32'd1);
    end

    // Flush in cycle 10 of a slow op: drains until the divider finishes.
    req_i = 1'b1; op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7;
    seen_done = 1'b0; busy_gap = 1'b0;
    for (int n = 0; n < 37; n++) begin
      flush_i = (n == 10);
      if (n == 11) req_i = 1'b0;
      @(negedge clk);
      if (done_o) seen_done = 1'b1;
      if (n >= 1 && !busy_o) busy_gap = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_done", {31'd0, seen_done}, 32'd0);
    check("flush_busy_held", {31'd0, busy_gap}, 32'd0);
    apply(2'b01, 32'd9, 32'd3, res, done_cyc, start_cnt, start_cyc, busy_cnt);
    $display("after flush: DIVU 9/3 -> %h at cycle %0d", res, done_cyc + 37);
    check("flush_next_result", res, 32'd3);
    check("flush_next_done_cycle", done_cyc + 37, 32'd74);
    check("flush_next_busy", busy_cnt, 32'd37);

    // Flush while in RESP: no pulse, delivered result unchanged.
    req_i = 1'b1; op_i = 2'b00; rs1_i = 32'd5; rs2_i = 32'd0;
    @(posedge clk); #1;
    req_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    check("resp_flush_done", {31'd0, done_o}, 32'd0);
    check("resp_flush_result", result_o, 32'd3);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("resp_flush_idle", {31'd0, busy_o}, 32'd0);
    check("resp_flush_result_held", result_o, 32'd3);
    $display("resp flush: result_o=%h", result_o);
    @(posedge clk); #1;

    // Reset in cycle 20 of a slow op.
    req_i = 1'b1; op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7;
    for (int n = 0; n < 21; n++) begin
      if (n == 20) begin rst = 1'b1; req_i = 1'b0; end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_result", result_o, 32'd0);
    check("rst_mid_flags", {29'd0, done_o, busy_o, div_start_o}, 32'd0);
    check("rst_mid_operands", div_dividend_o | div_divisor_o, 32'd0);
    @(posedge clk); #1;
    apply(2'b01, 32'd9, 32'd3, res, done_cyc, start_cnt, start_cyc, busy_cnt);
    $display("after reset: DIVU 9/3 -> %h at cycle %0d", res, done_cyc + 22);
    check("rst_next_result", res, 32'd3);
    check("rst_next_done_cycle", done_cyc + 22, 32'd59);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
